peripheral_msi_mux_master: RTL and testbench

Wishbone N-master to 1-slave bus switch that consumes the round-robin arbiter's registered `grant`/`selection`/`active` outputs and drives its `request` input. It locks the bus to one master for the whole `cyc` period and routes that master's request to the shared slave port. Responses go back to that master only. An optional watchdog aborts transactions the slave never answers.

---
 rtl/peripheral_msi_mux_master.sv | 192 +++++++++++++++++++
 tb/tb_peripheral_msi_mux_master.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/peripheral_msi_mux_master.sv
// Wishbone N-master to 1-slave switch driven by a registered round-robin arbiter.
// Define PERIPHERAL_MSI_MUX_TIMEOUT_EN to build the slave-response watchdog and ABORT path.
module peripheral_msi_mux_master #(
  parameter int NUM_PORTS = 6,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  // arbiter side
  output logic [NUM_PORTS-1:0]           arb_request,
  input  logic [NUM_PORTS-1:0]           arb_grant,
  input  logic [$clog2(NUM_PORTS)-1:0]   arb_selection,
  input  logic                           arb_active,
  // master ports, port k at [k*W +: W]
  input  logic [NUM_PORTS*AW-1:0]        m_adr_i,
  input  logic [NUM_PORTS*DW-1:0]        m_dat_i,
  input  logic [NUM_PORTS*(DW/8)-1:0]    m_sel_i,
  input  logic [NUM_PORTS-1:0]           m_we_i,
  input  logic [NUM_PORTS-1:0]           m_cyc_i,
  input  logic [NUM_PORTS-1:0]           m_stb_i,
  input  logic [NUM_PORTS*3-1:0]         m_cti_i,
  input  logic [NUM_PORTS*2-1:0]         m_bte_i,
  output logic [DW-1:0]                  m_dat_o,
  output logic [NUM_PORTS-1:0]           m_ack_o,
  output logic [NUM_PORTS-1:0]           m_err_o,
  output logic [NUM_PORTS-1:0]           m_rty_o,
  // slave port
  output logic [AW-1:0]                  s_adr_o,
  output logic [DW-1:0]                  s_dat_o,
  output logic [DW/8-1:0]                s_sel_o,
  output logic                           s_we_o,
  output logic                           s_cyc_o,
  output logic                           s_stb_o,
  output logic [2:0]                     s_cti_o,
  output logic [1:0]                     s_bte_o,
  input  logic [DW-1:0]                  s_dat_i,
  input  logic                           s_ack_i,
  input  logic                           s_err_i,
  input  logic                           s_rty_i,
  output logic                           bus_timeout,
  // debug view: state 0=IDLE 1=BUS 2=ABORT, plus the registered owner
  output logic [1:0]                     dbg_state_o,
  output logic [$clog2(NUM_PORTS)-1:0]   dbg_owner_o
);

  // Handshake: a master request is a cycle where cyc&stb are high; it completes on the
  // cycle where ack, err or rty is returned to that master (Wishbone classic/burst).

  localparam int SW = $clog2(NUM_PORTS);
  localparam int BW = DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_ABORT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] owner_q, owner_d;
  logic          sel_ok;
  logic          wd_fire;

  logic [AW-1:0] o_adr;
  logic [DW-1:0] o_dat;
  logic [BW-1:0] o_sel;
  logic          o_we;
  logic          o_cyc;
  logic          o_stb;
  logic [2:0]    o_cti;
  logic [1:0]    o_bte;

  assign arb_request = m_cyc_i;
  assign m_dat_o     = s_dat_i;
  assign dbg_state_o = state_q;
  assign dbg_owner_o = owner_q;
  assign bus_timeout = wd_fire;

  // A registered grant can be stale for one cycle after its master released.
  assign sel_ok = arb_active && arb_grant[arb_selection] && m_cyc_i[arb_selection]
                  && (int'(arb_selection) < NUM_PORTS);

  always_comb begin
    o_adr = m_adr_i[owner_q*AW +: AW];
    o_dat = m_dat_i[owner_q*DW +: DW];
    o_sel = m_sel_i[owner_q*BW +: BW];
    o_we  = m_we_i[owner_q];
    o_cyc = m_cyc_i[owner_q];
    o_stb = m_stb_i[owner_q];
    o_cti = m_cti_i[owner_q*3 +: 3];
    o_bte = m_bte_i[owner_q*2 +: 2];
  end

`ifdef PERIPHERAL_MSI_MUX_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] wd_cnt_q, wd_cnt_d;
  logic          any_resp;

  assign any_resp = s_ack_i || s_err_i || s_rty_i;

  // A response arriving on the firing cycle suppresses the abort.
  always_comb begin
    wd_cnt_d = '0;
    wd_fire  = 1'b0;
    if (state_q == ST_BUS && o_cyc && o_stb && !any_resp) begin
      if (wd_cnt_q == CW'(TIMEOUT - 1)) begin
        wd_fire = 1'b1;
      end else begin
        wd_cnt_d = wd_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_fire = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sel_ok) begin
          owner_d = arb_selection;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (!o_cyc) begin
          state_d = ST_IDLE;
        end else if (wd_fire) begin
          state_d = ST_ABORT;
        end
      end
      ST_ABORT: begin
        if (!o_cyc) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Only BUS connects anything; IDLE and ABORT present an idle slave and silent masters.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    m_rty_o = '0;
    if (state_q == ST_BUS) begin
      s_adr_o          = o_adr;
      s_dat_o          = o_dat;
      s_sel_o          = o_sel;
      s_we_o           = o_we;
      s_cyc_o          = o_cyc;
      s_stb_o          = o_stb;
      s_cti_o          = o_cti;
      s_bte_o          = o_bte;
      m_ack_o[owner_q] = s_ack_i;
      m_err_o[owner_q] = s_err_i | wd_fire;
      m_rty_o[owner_q] = s_rty_i;
    end
  end

endmodule

// File: tb/tb_peripheral_msi_mux_master.sv
// Bench for peripheral_msi_mux_master: bench-side round-robin arbiter, cycle model of the
// switch, directed scenarios then randomized masters/slave.
module tb_peripheral_msi_mux_master;
  localparam int NP = 6, AW = 32, DW = 32, BW = DW / 8, TO = 4, SW = $clog2(NP);
`ifdef PERIPHERAL_MSI_MUX_TIMEOUT_EN
  localparam bit TEN = 1'b1;
`else
  localparam bit TEN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NP-1:0]    arb_request, arb_grant;
  logic [SW-1:0]    arb_selection;
  logic             arb_active;
  logic [NP*AW-1:0] m_adr_i;
  logic [NP*DW-1:0] m_dat_i;
  logic [NP*BW-1:0] m_sel_i;
  logic [NP-1:0]    m_we_i, m_cyc_i, m_stb_i;
  logic [NP*3-1:0]  m_cti_i;
  logic [NP*2-1:0]  m_bte_i;
  logic [DW-1:0]    m_dat_o;
  logic [NP-1:0]    m_ack_o, m_err_o, m_rty_o;
  logic [AW-1:0]    s_adr_o;
  logic [DW-1:0]    s_dat_o;
  logic [BW-1:0]    s_sel_o;
  logic             s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]       s_cti_o;
  logic [1:0]       s_bte_o;
  logic [DW-1:0]    s_dat_i;
  logic             s_ack_i, s_err_i, s_rty_i;
  logic             bus_timeout;
  logic [1:0]       dbg_state_o;
  logic [SW-1:0]    dbg_owner_o;

  peripheral_msi_mux_master #(.NUM_PORTS(NP), .AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .arb_request(arb_request), .arb_grant(arb_grant),
    .arb_selection(arb_selection), .arb_active(arb_active),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i), .m_we_i(m_we_i),
    .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_cti_i(m_cti_i), .m_bte_i(m_bte_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .bus_timeout(bus_timeout), .dbg_state_o(dbg_state_o), .dbg_owner_o(dbg_owner_o)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // ref_own: master currently holding the slave (-1 = nobody); ref_abort: held but cut off.
  int  ref_own, ref_wait, ref_reg, rr_last;
  bit  ref_abort;
  logic [NP-1:0] seen_resp, seen_err;

  task automatic model_edge();
    int found;
    if (rst) begin
      ref_own = -1; ref_abort = 0; ref_wait = 0; ref_reg = 0;
    end else if (ref_own < 0) begin
      if (arb_active && arb_grant[arb_selection] && m_cyc_i[arb_selection]) begin
        ref_own = int'(arb_selection);
        ref_reg = ref_own;
      end
    end else if (!m_cyc_i[ref_own]) begin
      ref_own = -1; ref_abort = 0; ref_wait = 0;
    end else if (!ref_abort) begin
      if (m_stb_i[ref_own] && !(s_ack_i || s_err_i || s_rty_i)) begin
        if (TEN && ref_wait == TO - 1) begin
          ref_abort = 1; ref_wait = 0;
        end else begin
          ref_wait++;
        end
      end else begin
        ref_wait = 0;
      end
    end
    // registered round-robin arbiter, holds while the granted master keeps cyc
    if (rst) begin
      arb_grant = '0; arb_active = 1'b0; arb_selection = '0; rr_last = NP - 1;
    end else if (!(arb_active && m_cyc_i[arb_selection])) begin
      found = -1;
      for (int i = 1; i <= NP; i++) begin
        if (found < 0 && m_cyc_i[(rr_last + i) % NP]) found = (rr_last + i) % NP;
      end
      arb_grant = '0;
      if (found >= 0) begin
        arb_grant[found] = 1'b1; arb_selection = SW'(found); arb_active = 1'b1; rr_last = found;
      end else begin
        arb_active = 1'b0;
      end
    end
  endtask

  task automatic check_cycle();
    bit busy, fire, no_resp;
    int o;
    logic [NP-1:0] e_ack, e_err, e_rty;
    busy    = (ref_own >= 0) && !ref_abort;
    o       = busy ? ref_own : 0;
    no_resp = !(s_ack_i || s_err_i || s_rty_i);
    fire    = TEN && busy && m_cyc_i[o] && m_stb_i[o] && no_resp && (ref_wait == TO - 1);
    e_ack = '0; e_err = '0; e_rty = '0;
    if (busy) begin
      e_ack[o] = s_ack_i; e_err[o] = s_err_i | fire; e_rty[o] = s_rty_i;
    end
    check_eq("arb_request", arb_request, m_cyc_i);
    check_eq("m_dat_o", m_dat_o, s_dat_i);
    check_eq("s_cyc_o", s_cyc_o, busy & m_cyc_i[o]);
    check_eq("s_stb_o", s_stb_o, busy & m_stb_i[o]);
    check_eq("s_we_o", s_we_o, busy & m_we_i[o]);
    check_eq("s_adr_o", s_adr_o, busy ? m_adr_i[o*AW +: AW] : {AW{1'b0}});
    check_eq("s_dat_o", s_dat_o, busy ? m_dat_i[o*DW +: DW] : {DW{1'b0}});
    check_eq("s_sel_o", s_sel_o, busy ? m_sel_i[o*BW +: BW] : {BW{1'b0}});
    check_eq("s_cti_o", s_cti_o, busy ? m_cti_i[o*3 +: 3] : 3'b000);
    check_eq("s_bte_o", s_bte_o, busy ? m_bte_i[o*2 +: 2] : 2'b00);
    check_eq("m_ack_o", m_ack_o, e_ack);
    check_eq("m_err_o", m_err_o, e_err);
    check_eq("m_rty_o", m_rty_o, e_rty);
    check_eq("bus_timeout", bus_timeout, fire);
    check_eq("dbg_state", dbg_state_o, (ref_own < 0) ? 2'd0 : (ref_abort ? 2'd2 : 2'd1));
    check_eq("dbg_owner", dbg_owner_o, ref_reg);
    seen_resp = e_ack | e_err | e_rty;
    seen_err  = e_err;
  endtask

  task automatic at_neg();  @(negedge clk); check_cycle(); endtask
  task automatic to_next(); @(posedge clk); #1; model_edge(); endtask
  task automatic run_cycle(); at_neg(); to_next(); endtask

  // ---------------- drivers ----------------
  int beats[NP], idle[NP];

  task automatic clear_all();
    m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; m_we_i = '0; m_cyc_i = '0; m_stb_i = '0;
    m_cti_i = '0; m_bte_i = '0; s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;
  endtask

  task automatic set_master(input int k, input logic [AW-1:0] adr, input logic we, input logic [2:0] cti);
    m_cyc_i[k] = 1'b1; m_stb_i[k] = 1'b1; m_we_i[k] = we;
    m_adr_i[k*AW +: AW] = adr; m_dat_i[k*DW +: DW] = 32'hA5A5_0000 + 32'(k);
    m_sel_i[k*BW +: BW] = '1; m_cti_i[k*3 +: 3] = cti; m_bte_i[k*2 +: 2] = 2'b00;
  endtask

  task automatic drop(input int k);
    m_cyc_i[k] = 1'b0; m_stb_i[k] = 1'b0;
  endtask

  task automatic new_beat(input int k);
    m_adr_i[k*AW +: AW] = $urandom; m_dat_i[k*DW +: DW] = $urandom;
    m_sel_i[k*BW +: BW] = BW'($urandom); m_we_i[k] = 1'($urandom);
    m_cti_i[k*3 +: 3] = 3'($urandom); m_bte_i[k*2 +: 2] = 2'($urandom);
    m_stb_i[k] = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drive_random();
    for (int k = 0; k < NP; k++) begin
      if (m_cyc_i[k]) begin
        if (seen_resp[k]) begin
          beats[k]--;
          if (beats[k] <= 0 || seen_err[k]) begin
            drop(k); idle[k] = $urandom_range(0, 6);
          end else begin
            new_beat(k);
          end
        end else if (!m_stb_i[k]) begin
          m_stb_i[k] = 1'b1;
        end
      end else if (idle[k] > 0) begin
        idle[k]--;
      end else if ($urandom_range(0, 2) == 0) begin
        beats[k] = $urandom_range(1, 5); m_cyc_i[k] = 1'b1; new_beat(k);
      end
    end
  endtask

  // slave answers only while a strobe is presented to it
  task automatic slave_drive();
    bit stb_now;
    int r;
    stb_now = (ref_own >= 0) && !ref_abort && m_stb_i[(ref_own < 0) ? 0 : ref_own];
    r = $urandom_range(0, 9);
    s_dat_i = $urandom;
    s_ack_i = stb_now && (r < 6);
    s_err_i = stb_now && (r == 6);
    s_rty_i = stb_now && (r == 7);
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1; clear_all();
    arb_grant = '0; arb_selection = '0; arb_active = 1'b0;
    ref_own = -1; ref_abort = 0; ref_wait = 0; ref_reg = 0; rr_last = NP - 1;
    seen_resp = '0; seen_err = '0;
    for (int k = 0; k < NP; k++) begin beats[k] = 0; idle[k] = 0; end
    repeat (2) @(posedge clk);
    #1; model_edge();
    at_neg();
    check_eq("rst_s_cyc", s_cyc_o, 1'b0); check_eq("rst_state", dbg_state_o, 2'd0);
    to_next();
    rst = 1'b0;
    repeat (2) run_cycle();

    // single master 2, ack in cycle 4
    set_master(2, 32'h100, 1'b1, 3'b000);
    run_cycle();                                                              // c0
    at_neg(); check_eq("t1_lat_c1", s_cyc_o, 1'b0); to_next();               // c1
    at_neg(); check_eq("t1_cyc_c2", s_cyc_o, 1'b1);
    check_eq("t1_adr", s_adr_o, 32'h100); to_next();                          // c2
    run_cycle();                                                              // c3
    s_ack_i = 1'b1;
    at_neg(); check_eq("t1_ack", m_ack_o, 6'b000100); to_next();             // c4
    s_ack_i = 1'b0; drop(2);
    at_neg(); check_eq("t1_rel_cyc", s_cyc_o, 1'b0); to_next();              // c5
    at_neg(); check_eq("t1_idle", dbg_state_o, 2'd0); to_next();             // c6

    // contention between masters 0 and 3 from a fresh arbiter
    rst = 1'b1; run_cycle(); rst = 1'b0; run_cycle();
    set_master(0, 32'h200, 1'b1, 3'b000); set_master(3, 32'h300, 1'b0, 3'b000);
    run_cycle(); run_cycle();                                                 // c0 c1
    at_neg(); check_eq("t2_first", dbg_owner_o, 3'd0);
    check_eq("t2_adr0", s_adr_o, 32'h200); to_next();                         // c2
    s_ack_i = 1'b1;
    at_neg(); check_eq("t2_ack0", m_ack_o, 6'b000001); to_next();            // c3
    s_ack_i = 1'b0; drop(0);
    run_cycle();                                                              // c4 = n
    at_neg(); check_eq("t2_gap", s_cyc_o, 1'b0); to_next();                  // n+1
    at_neg(); check_eq("t2_cyc3", s_cyc_o, 1'b1); check_eq("t2_adr3", s_adr_o, 32'h300);
    check_eq("t2_own3", dbg_owner_o, 3'd3); to_next();                        // n+2
    s_ack_i = 1'b1;
    at_neg(); check_eq("t2_ack3", m_ack_o, 6'b001000); to_next();
    s_ack_i = 1'b0; drop(3);
    repeat (2) run_cycle();

    // 4-beat burst from master 1, acked every cycle
    set_master(1, 32'h400, 1'b1, 3'b010);
    run_cycle(); run_cycle();
    for (int i = 0; i < 4; i++) begin
      m_adr_i[1*AW +: AW] = 32'h400 + 32'(4 * i);
      m_cti_i[3 +: 3] = (i == 3) ? 3'b111 : 3'b010;
      s_ack_i = 1'b1;
      at_neg();
      check_eq("t3_ack", m_ack_o, 6'b000010);
      check_eq("t3_cti", s_cti_o, (i == 3) ? 3'b111 : 3'b010);
      to_next();
    end
    s_ack_i = 1'b0; drop(1);
    repeat (2) run_cycle();

    // unanswered master 5
    set_master(5, 32'h500, 1'b0, 3'b000);
    run_cycle(); run_cycle();
`ifdef PERIPHERAL_MSI_MUX_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      at_neg(); check_eq("t4_no_err", m_err_o, 6'b000000); to_next();
    end
    at_neg(); check_eq("t4_err", m_err_o, 6'b100000);
    check_eq("t4_timeout", bus_timeout, 1'b1); to_next();
    for (int i = 0; i < 3; i++) begin
      at_neg(); check_eq("t4_abort_cyc", s_cyc_o, 1'b0);
      check_eq("t4_abort_st", dbg_state_o, 2'd2); to_next();
    end
`else
    for (int i = 0; i < 100; i++) begin
      at_neg(); check_eq("t4_hang", dbg_state_o, 2'd1); to_next();
    end
`endif
    drop(5);
    repeat (2) run_cycle();

    // late response on the 4th strobe cycle
    set_master(5, 32'h540, 1'b0, 3'b000);
    run_cycle(); run_cycle();
    repeat (3) run_cycle();
    s_ack_i = 1'b1;
    at_neg(); check_eq("t5_ack", m_ack_o, 6'b100000);
    check_eq("t5_err", m_err_o, 6'b000000); check_eq("t5_to", bus_timeout, 1'b0); to_next();
    s_ack_i = 1'b0; drop(5);
    run_cycle();
    at_neg(); check_eq("t5_idle", dbg_state_o, 2'd0); to_next();

    // reset in the middle of master 4's cycle
    set_master(4, 32'h600, 1'b1, 3'b000);
    repeat (3) run_cycle();
    rst = 1'b1;
    at_neg(); check_eq("t6_pre", s_cyc_o, 1'b1); to_next();
    rst = 1'b0; s_ack_i = 1'b1;
    at_neg();
    check_eq("t6_cyc", s_cyc_o, 1'b0); check_eq("t6_ack", m_ack_o, 6'b000000);
    check_eq("t6_state", dbg_state_o, 2'd0); check_eq("t6_owner", dbg_owner_o, 3'd0);
    to_next();
    s_ack_i = 1'b0; drop(4);
    repeat (3) run_cycle();

    // randomized traffic with occasional resets
    clear_all();
    repeat (3000) begin
      drive_random();
      rst = ($urandom_range(0, 399) == 0);
      slave_drive();
      run_cycle();
    end
    rst = 1'b0; clear_all();
    repeat (10) run_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
